// File: rtl/fifo_frame_tx_if.sv
// Descriptor handshake, FIFO read port and wire byte stream of the frame transmitter.
// The transmitter connects through the slave modport; its environment uses master.
interface fifo_frame_tx_if #(
    parameter int LEN_W = 11
);
    logic [LEN_W-1:0] frame_len;
    logic             frame_valid;
    logic             frame_ready;
    logic [7:0]       fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             tx_en;
    logic             tx_er;
    logic [7:0]       tx_data;
    logic             underrun;

    modport master (
        output frame_len, frame_valid, fifo_dout, fifo_empty,
        input  frame_ready, fifo_rd_en, tx_en, tx_er, tx_data, underrun
    );

    modport slave (
        input  frame_len, frame_valid, fifo_dout, fifo_empty,
        output frame_ready, fifo_rd_en, tx_en, tx_er, tx_data, underrun
    );
endinterface

// File: rtl/fifo_frame_tx.sv
// Frame transmitter: drains a byte FIFO into preamble/SFD/payload/pad frames
// with a guaranteed inter-frame gap; underruns are marked and the frame is flushed.
//   state    | meaning
//   IDLE     | frame_ready high, waiting for a descriptor
//   PREAMBLE | seven 0x55 bytes
//   SFD      | 0xD5 byte, pre-fetch of payload byte 0
//   PAYLOAD  | forward FIFO bytes, one read in flight
//   PAD      | zero bytes until payload+pad reaches MIN_LEN
//   DRAIN    | after an underrun: read and discard the rest of the frame
//   IFG      | idle gap before the next descriptor
module fifo_frame_tx #(
    parameter int LEN_W   = 11,
    parameter int MIN_LEN = 60,
    parameter int IFG     = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_frame_tx_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;
    localparam logic [2:0] S_IFG      = 3'd6;

    localparam int TMR_W = ($clog2(IFG + 1) > 3) ? $clog2(IFG + 1) : 3;
    localparam logic [TMR_W-1:0] TMR_PRE   = TMR_W'(6);
    localparam logic [TMR_W-1:0] TMR_IFG   = TMR_W'(IFG);
    localparam logic [LEN_W:0]   MIN_LEN_X = (LEN_W + 1)'(MIN_LEN);

    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_req_cnt;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [TMR_W-1:0] r_tmr;
    logic             r_rd_pend;
    logic             r_ur_pend;
    logic             r_tx_en;
    logic             r_tx_er;
    logic [7:0]       r_tx_data;
    logic             r_underrun;

    logic             w_req_open;
    logic             w_rd_en;
    logic [LEN_W:0]   w_byte_nxt;
    logic             w_last_pay;
    logic             w_last_pad;
    logic             w_short;

    always_comb begin
        w_req_open = 1'b0;
        w_rd_en    = 1'b0;
        w_byte_nxt = '0;
        w_last_pay = 1'b0;
        w_last_pad = 1'b0;
        w_short    = 1'b0;

        w_req_open = (r_req_cnt < r_len_q);
        w_rd_en    = w_req_open && !bus.fifo_empty &&
                     ((r_state == S_SFD) || (r_state == S_DRAIN) ||
                      ((r_state == S_PAYLOAD) && !r_ur_pend));
        w_byte_nxt = {1'b0, r_byte_cnt} + 1'b1;
        w_last_pay = (w_byte_nxt == {1'b0, r_len_q});
        w_last_pad = (w_byte_nxt == MIN_LEN_X);
        w_short    = ({1'b0, r_len_q} < MIN_LEN_X);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len_q    <= '0;
            r_req_cnt  <= '0;
            r_byte_cnt <= '0;
            r_tmr      <= '0;
            r_rd_pend  <= 1'b0;
            r_ur_pend  <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_underrun <= 1'b0;
        end else begin
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_underrun <= 1'b0;
            r_rd_pend  <= w_rd_en;
            if (w_rd_en) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.frame_valid) begin
                        r_len_q    <= bus.frame_len;
                        r_req_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_ur_pend  <= 1'b0;
                        r_tmr      <= TMR_PRE;
                        r_state    <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    r_tx_en   <= 1'b1;
                    r_tx_data <= 8'h55;
                    if (r_tmr == '0) begin
                        r_state <= S_SFD;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_SFD: begin
                    // Gap timer is armed here; PAYLOAD, PAD and DRAIN leave it untouched.
                    r_tx_en   <= 1'b1;
                    r_tx_data <= 8'hD5;
                    r_tmr     <= TMR_IFG;
                    if (r_len_q == '0) begin
                        r_state <= w_short ? S_PAD : S_IFG;
                    end else begin
                        r_ur_pend <= bus.fifo_empty;
                        r_state   <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (r_rd_pend) begin
                        r_tx_en    <= 1'b1;
                        r_tx_data  <= bus.fifo_dout;
                        r_byte_cnt <= w_byte_nxt[LEN_W-1:0];
                        if (w_last_pay) begin
                            r_state <= w_short ? S_PAD : S_IFG;
                        end
                    end else if (r_ur_pend) begin
                        // The slot of the missing byte carries the error marker.
                        r_tx_en    <= 1'b1;
                        r_tx_er    <= 1'b1;
                        r_underrun <= 1'b1;
                        r_state    <= S_DRAIN;
                    end
                    if (w_req_open && bus.fifo_empty) begin
                        r_ur_pend <= 1'b1;
                    end
                end
                S_PAD: begin
                    r_tx_en    <= 1'b1;
                    r_byte_cnt <= w_byte_nxt[LEN_W-1:0];
                    if (w_last_pad) begin
                        r_state <= S_IFG;
                    end
                end
                S_DRAIN: begin
                    if (!w_req_open) begin
                        r_state <= S_IFG;
                    end
                end
                S_IFG: begin
                    if (r_tmr == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.frame_ready = (r_state == S_IDLE);
    assign bus.fifo_rd_en  = w_rd_en;
    assign bus.tx_en       = r_tx_en;
    assign bus.tx_er       = r_tx_er;
    assign bus.tx_data     = r_tx_data;
    assign bus.underrun    = r_underrun;
endmodule

// File: tb/tb_fifo_frame_tx.sv
// Directed bench for fifo_frame_tx: a byte FIFO model feeds the DUT, a monitor
// captures the wire, and each step compares against hand-built expected frames.
module tb_fifo_frame_tx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fifo_frame_tx_if #(.LEN_W(11)) bus ();

    fifo_frame_tx #(.LEN_W(11), .MIN_LEN(60), .IFG(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, flushed while reset is held.
    logic [7:0]  mem [256];
    logic [15:0] wr_ptr = '0;
    logic [15:0] rd_ptr = '0;
    int          n_rd   = 0;
    int          n_viol = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en) begin
            if (wr_ptr == rd_ptr) begin
                n_viol <= n_viol + 1;
            end else begin
                bus.fifo_dout <= mem[rd_ptr[7:0]];
                rd_ptr        <= rd_ptr + 16'd1;
                n_rd          <= n_rd + 1;
            end
        end
    end

    // Cycle counter and descriptor acceptance.
    int cyc     = 0;
    int n_acc   = 0;
    int acc_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.frame_valid && bus.frame_ready) begin
            n_acc   <= n_acc + 1;
            acc_cyc <= cyc;
        end
    end

    // Wire monitor.
    logic [8:0] cap_q [$];
    int   low_run    = 0;
    int   last_gap   = 0;
    int   ready_gap  = 0;
    int   rise_cyc   = 0;
    int   n_ur       = 0;
    logic prev_en    = 1'b0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (bus.frame_ready && !prev_ready) begin
            ready_gap <= low_run;
        end
        if (bus.tx_en) begin
            cap_q.push_back({bus.tx_er, bus.tx_data});
            if (!prev_en) begin
                last_gap <= low_run;
                rise_cyc <= cyc;
            end
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        if (bus.underrun) begin
            n_ur <= n_ur + 1;
        end
        prev_en    <= bus.tx_en;
        prev_ready <= bus.frame_ready;
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic exp_pre();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
    endtask

    task automatic exp_byte(input logic er, input logic [7:0] b);
        exp_q.push_back({er, b});
    endtask

    task automatic wait_ready(input string tag, input int limit);
        int n = 0;
        while (!bus.frame_ready && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.frame_ready), 32'd1);
    endtask

    task automatic start(input string tag, input logic [10:0] len);
        wait_ready(tag, 300);
        bus.frame_len   = len;
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    task automatic cmp_wire(input string tag, input int base);
        int nbad = 0;
        chk({tag, "_len"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= cap_q.size()) nbad++;
            else if (cap_q[base + i] !== exp_q[i]) nbad++;
        end
        chk({tag, "_data"}, 32'(nbad), 32'd0);
    endtask

    int base;
    int rd0;
    int ur0;
    int acc0;
    int nw;

    initial begin
        bus.frame_valid = 1'b0;
        bus.frame_len   = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_txen",  32'(bus.tx_en), 32'd0);
        chk("rst_flags", 32'({bus.tx_er, bus.underrun, bus.fifo_rd_en}), 32'd0);
        chk("rst_data",  32'(bus.tx_data), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(bus.frame_ready), 32'd1);

        // Full-size frame
        for (int i = 0; i < 64; i++) push(8'(i));
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 64; i++) exp_byte(1'b0, 8'(i));
        base = cap_q.size(); rd0 = n_rd; ur0 = n_ur;
        start("full", 11'd64);
        wait_ready("full_end", 300);
        tick();
        cmp_wire("full", base);
        chk("full_reads",   32'(n_rd - rd0), 32'd64);
        chk("full_empty",   32'(bus.fifo_empty), 32'd1);
        chk("full_latency", 32'(rise_cyc - acc_cyc), 32'd2);
        chk("full_ifg",     32'(ready_gap), 32'd12);
        chk("full_ur",      32'(n_ur - ur0), 32'd0);

        // Padded frame
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 10; i++) exp_byte(1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < 50; i++) exp_byte(1'b0, 8'h00);
        base = cap_q.size(); rd0 = n_rd;
        start("pad", 11'd10);
        wait_ready("pad_end", 300);
        tick();
        cmp_wire("pad", base);
        chk("pad_reads", 32'(n_rd - rd0), 32'd10);
        chk("pad_ifg",   32'(ready_gap), 32'd12);

        // Empty payload; a byte sits in the FIFO and must not be read
        push(8'h10);
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 60; i++) exp_byte(1'b0, 8'h00);
        base = cap_q.size(); rd0 = n_rd;
        start("zero", 11'd0);
        wait_ready("zero_end", 300);
        tick();
        cmp_wire("zero", base);
        chk("zero_reads", 32'(n_rd - rd0), 32'd0);

        // Underrun: 20 bytes available for a 40-byte frame
        for (int i = 1; i < 20; i++) push(8'h10 + 8'(i));
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 20; i++) exp_byte(1'b0, 8'h10 + 8'(i));
        exp_byte(1'b1, 8'h00);
        base = cap_q.size(); rd0 = n_rd; ur0 = n_ur;
        start("ur", 11'd40);
        repeat (60) tick();
        cmp_wire("ur", base);
        chk("ur_pulse",    32'(n_ur - ur0), 32'd1);
        chk("ur_reads",    32'(n_rd - rd0), 32'd20);
        chk("ur_draining", 32'(bus.frame_ready), 32'd0);
        for (int i = 0; i < 20; i++) push(8'hE0 + 8'(i));
        wait_ready("ur_end", 300);
        tick();
        chk("ur_drain_reads", 32'(n_rd - rd0), 32'd40);
        chk("ur_drain_empty", 32'(bus.fifo_empty), 32'd1);
        chk("ur_pulse_once",  32'(n_ur - ur0), 32'd1);
        chk("ur_wire_quiet",  32'(cap_q.size() - base), 32'd29);

        // Next frame after the flush starts aligned
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 5; i++) exp_byte(1'b0, 8'hC0 + 8'(i));
        for (int i = 0; i < 55; i++) exp_byte(1'b0, 8'h00);
        base = cap_q.size(); rd0 = n_rd;
        start("align", 11'd5);
        wait_ready("align_end", 300);
        tick();
        cmp_wire("align", base);
        chk("align_reads", 32'(n_rd - rd0), 32'd5);

        // Back-to-back descriptors with frame_valid held high
        for (int i = 0; i < 128; i++) push(8'(i));
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 64; i++) exp_byte(1'b0, 8'(i));
        exp_pre();
        for (int i = 64; i < 128; i++) exp_byte(1'b0, 8'(i));
        base = cap_q.size(); rd0 = n_rd; acc0 = n_acc;
        bus.frame_len   = 11'd64;
        bus.frame_valid = 1'b1;
        nw = 0;
        while (n_acc < acc0 + 2 && nw < 400) begin
            tick();
            nw++;
        end
        bus.frame_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc - acc0), 32'd2);
        wait_ready("b2b_end", 300);
        tick();
        cmp_wire("b2b", base);
        chk("b2b_gap",   32'(last_gap), 32'd14);
        chk("b2b_reads", 32'(n_rd - rd0), 32'd128);

        // Reset in the middle of PAYLOAD
        for (int i = 0; i < 64; i++) push(8'h80 + 8'(i));
        start("mid", 11'd64);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txen", 32'(bus.tx_en), 32'd0);
        chk("mid_rst_txer", 32'(bus.tx_er), 32'd0);
        chk("mid_rst_rden", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("mid_ready", 32'(bus.frame_ready), 32'd1);
        tick();
        for (int i = 0; i < 64; i++) push(8'h40 + 8'(i));
        exp_q.delete();
        exp_pre();
        for (int i = 0; i < 64; i++) exp_byte(1'b0, 8'h40 + 8'(i));
        base = cap_q.size(); rd0 = n_rd;
        start("fresh", 11'd64);
        wait_ready("fresh_end", 300);
        tick();
        cmp_wire("fresh", base);
        chk("fresh_reads", 32'(n_rd - rd0), 32'd64);

        chk("rd_when_empty", 32'(n_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
